// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register-dump sequencer: FSM state encoding,
// MIPS I-type field positions and the ADDI opcode used to probe registers.
package reg_dump_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StIssue,
      StWait,
      StPresent,
      StDone
   } state_e;

   localparam int unsigned NUM_REGS = 32;

   localparam logic [5:0] OPC_ADDI = 6'b001000;

   // I-type instruction field positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;

   // ADDI $0, rs, 0: reads rs onto port A and writes only to $0, so it is harmless
   function automatic logic [31:0] make_addi(input logic [4:0] rs);
      logic [31:0] inst;
      inst                  = '0;
      inst[OPC_MSB:OPC_LSB] = OPC_ADDI;
      inst[RS_MSB:RS_LSB]   = rs;
      inst[RT_MSB:RT_LSB]   = 5'd0;
      inst[IMM_MSB:IMM_LSB] = 16'h0000;
      return inst;
   endfunction

endpackage

// File: rtl/reg_dump_ctrl_dump_wait_ctr.sv
// Loadable down-counter with a zero flag. Shared by the drain phase and the
// pipeline-latency wait; it saturates at zero.
module dump_wait_ctr #(
   parameter int unsigned Width = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] count_q, count_d;

   // Load has priority over decrement
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file dump sequencer. Takes over the pipeline instruction input,
// drains it with NOPs, then injects one ADDI per register so the value shows
// up on the port-A probe, and streams the captured values out.
// Optional build macro REG_DUMP_SKIP_R0_EN: start at $1 and never read $0.
module reg_dump_ctrl
   import reg_dump_ctrl_pkg::*;
#(
   parameter int unsigned PIPE_LAT     = 2,
   parameter int unsigned DRAIN_CYCLES = 5,
   parameter logic [31:0] NOP_INST     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [31:0] bus_a_probe_i,
   input  logic        dump_ready_i,
   output logic        override_inst_o,
   output logic [31:0] force_inst_o,
   output logic        dump_valid_o,
   output logic [4:0]  dump_idx_o,
   output logic [31:0] dump_data_o,
   output logic        busy_o,
   output logic        done_o
);

`ifdef REG_DUMP_SKIP_R0_EN
   localparam logic [4:0] StartIdx = 5'd1;
`else
   localparam logic [4:0] StartIdx = 5'd0;
`endif

   localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

   // Counter only ever holds load values, i.e. at most max(...) - 1
   localparam int unsigned CtrMax = (DRAIN_CYCLES > PIPE_LAT) ? DRAIN_CYCLES : PIPE_LAT;
   localparam int unsigned CtrW   = (CtrMax > 1) ? $clog2(CtrMax) : 1;
   localparam logic [CtrW-1:0] DrainLoad = CtrW'(DRAIN_CYCLES - 1);
   localparam logic [CtrW-1:0] WaitLoad  = CtrW'(PIPE_LAT - 1);

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;

   logic        override_q, override_d;
   logic [31:0] force_q, force_d;
   logic        valid_q, valid_d;
   logic [4:0]  dump_idx_q, dump_idx_d;
   logic [31:0] dump_data_q, dump_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic            ctr_load;
   logic [CtrW-1:0] ctr_load_val;
   logic            ctr_dec;
   logic            ctr_zero;
   logic            capture;

   dump_wait_ctr #(
      .Width (CtrW)
   ) u_wait_ctr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (ctr_load),
      .load_val_i (ctr_load_val),
      .dec_i      (ctr_dec),
      .zero_o     (ctr_zero)
   );

   // Next-state, register index and counter control
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      ctr_load     = 1'b0;
      ctr_load_val = '0;
      ctr_dec      = 1'b0;
      capture      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d      = StDrain;
               idx_d        = StartIdx;
               ctr_load     = 1'b1;
               ctr_load_val = DrainLoad;
            end
         end
         StDrain: begin
            if (ctr_zero) begin
               state_d = StIssue;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         StIssue: begin
            state_d      = StWait;
            ctr_load     = 1'b1;
            ctr_load_val = WaitLoad;
         end
         StWait: begin
            if (ctr_zero) begin
               state_d = StPresent;
               capture = 1'b1;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         StPresent: begin
            if (dump_ready_i) begin
               // Termination is checked before the increment, so idx never wraps
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StIssue;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output next-values decoded from the state being entered, so every output is a flop
   always_comb begin
      override_d  = 1'b0;
      force_d     = NOP_INST;
      valid_d     = 1'b0;
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      dump_idx_d  = dump_idx_q;
      dump_data_d = dump_data_q;
      unique case (state_d)
         StDrain: begin
            override_d = 1'b1;
         end
         StIssue, StWait: begin
            override_d = 1'b1;
            force_d    = make_addi(idx_d);
         end
         StPresent: begin
            override_d = 1'b1;
            valid_d    = 1'b1;
         end
         default: begin
            override_d = 1'b0;
         end
      endcase
      if (capture) begin
         dump_idx_d  = idx_q;
         dump_data_d = bus_a_probe_i;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         override_q  <= 1'b0;
         force_q     <= '0;
         valid_q     <= 1'b0;
         dump_idx_q  <= '0;
         dump_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         override_q  <= override_d;
         force_q     <= force_d;
         valid_q     <= valid_d;
         dump_idx_q  <= dump_idx_d;
         dump_data_q <= dump_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign override_inst_o = override_q;
   assign force_inst_o    = force_q;
   assign dump_valid_o    = valid_q;
   assign dump_idx_o      = dump_idx_q;
   assign dump_data_o     = dump_data_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl. A two-stage pipeline model turns the
// injected instruction's rs field into a register-file read on the probe bus.
module tb_reg_dump_ctrl;

`ifdef REG_DUMP_SKIP_R0_EN
   localparam int SI = 1;
`else
   localparam int SI = 0;
`endif
   localparam int NWORDS = 32 - SI;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] bus_a_probe;
   logic        dump_ready;
   logic        override_inst;
   logic [31:0] force_inst;
   logic        dump_valid;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];
   logic [4:0]  p1 = 5'd0;
   logic [4:0]  p2 = 5'd0;

   int checks   = 0;
   int failures = 0;

   reg_dump_ctrl #(
      .PIPE_LAT     (2),
      .DRAIN_CYCLES (5),
      .NOP_INST     (32'h0000_0000)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_i         (start),
      .bus_a_probe_i   (bus_a_probe),
      .dump_ready_i    (dump_ready),
      .override_inst_o (override_inst),
      .force_inst_o    (force_inst),
      .dump_valid_o    (dump_valid),
      .dump_idx_o      (dump_idx),
      .dump_data_o     (dump_data),
      .busy_o          (busy),
      .done_o          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipeline model: rs of the instruction entering the pipe is on the probe two edges later
   always @(posedge clk) begin
      p1 <= override_inst ? force_inst[25:21] : 5'd0;
      p2 <= p1;
   end
   assign bus_a_probe = rf[p2];

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] addi(input int r);
      return 32'h2000_0000 | (32'(r) << 21);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs until busy drops, checking every presented word; pokes start while idx poke_idx is shown
   task automatic run_to_idle(input int first_idx, input int poke_idx,
                              output int words, output int dones, output int last_edge);
      int n;
      int e;
      n = 0;
      e = first_idx;
      words = 0;
      dones = 0;
      last_edge = -1;
      while (busy === 1'b1 && n < 400) begin
         if (dump_valid === 1'b1) begin
            chk("word_idx", 32'(dump_idx), 32'(e));
            chk("word_data", dump_data, rf[e]);
            if (e == 5) chk("reg5_deadbeef", dump_data, 32'hDEAD_BEEF);
            if (e == 31) chk("reg31_12345678", dump_data, 32'h1234_5678);
            if (e == poke_idx) start = 1'b1;
            words++;
            e++;
         end
         if (done === 1'b1) begin
            dones++;
            last_edge = n;
         end
         tick();
         start = 1'b0;
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
      chk("done_low_in_idle", 32'(done), 32'd0);
      chk("override_low_in_idle", 32'(override_inst), 32'd0);
   endtask

   int n;
   int words;
   int dones;
   int last_edge;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + 32'(i * 32'h0001_0101);
      rf[0]  = 32'h0000_0000;
      rf[5]  = 32'hDEAD_BEEF;
      rf[31] = 32'h1234_5678;

      reset = 1'b1;
      start = 1'b0;
      dump_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_override", 32'(override_inst), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_valid", 32'(dump_valid), 32'd0);
         chk("idle_force", force_inst, 32'd0);
         chk("idle_done", 32'(done), 32'd0);
      end

      // 2: full dump with ready tied high
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("drain_override", 32'(override_inst), 32'd1);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_force_nop", force_inst, 32'd0);
      n = 1;
      while (dump_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("first_valid_edge", 32'(n), 32'd9);
      chk("first_idx", 32'(dump_idx), 32'(SI));
      run_to_idle(SI, -1, words, dones, last_edge);
      chk("full_words", 32'(words), 32'(NWORDS));
      chk("full_dones", 32'(dones), 32'd1);
      chk("full_done_edge", 32'(n + last_edge), 32'(9 + (NWORDS - 1) * 4 + 1));

      // 3: stall at idx 3
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(dump_valid === 1'b1 && dump_idx === 5'd3) && n < 100) begin
         tick();
         n++;
      end
      chk("stall_reach_idx", 32'(dump_idx), 32'd3);
      dump_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", 32'(dump_valid), 32'd1);
         chk("stall_idx", 32'(dump_idx), 32'd3);
         chk("stall_data", dump_data, rf[3]);
         chk("stall_force_nop", force_inst, 32'd0);
      end
      dump_ready = 1'b1;
      tick();
      chk("release_valid", 32'(dump_valid), 32'd0);
      chk("release_issue4", force_inst, addi(4));
      run_to_idle(4, -1, words, dones, last_edge);
      chk("stall_words", 32'(words), 32'd28);
      chk("stall_dones", 32'(dones), 32'd1);

      // 4: reset while waiting on idx 7
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (force_inst !== addi(7) && n < 100) begin
         tick();
         n++;
      end
      chk("issue7_seen", force_inst, addi(7));
      tick();
      chk("wait7_force", force_inst, addi(7));
      chk("wait7_valid", 32'(dump_valid), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_override", 32'(override_inst), 32'd0);
      chk("abort_valid", 32'(dump_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_force", force_inst, 32'd0);

      // 5: restart from the beginning; start poked during PRESENT is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (dump_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("restart_first_edge", 32'(n), 32'd9);
      chk("restart_first_idx", 32'(dump_idx), 32'(SI));
      run_to_idle(SI, SI + 2, words, dones, last_edge);
      chk("poke_words", 32'(words), 32'(NWORDS));
      chk("poke_dones", 32'(dones), 32'd1);
      tick();
      chk("poke_no_restart", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
